// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx: 8N1 serial transmitter for an ASCII byte stream (optional even parity under UART_PARITY_EN).
// Latency: tx falls the cycle after char_valid&char_ready; frame = 10*CLKS_PER_BIT cycles (11* with parity).
// Backpressure: char_ready is high only in IDLE, so each frame is followed by exactly one IDLE cycle.
module ascii_uart_tx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       tx,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // Last timer value of a bit period; the timer wraps to 0 after it.
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  idx_q,   idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        tx_q,    tx_d;
    logic        busy_q,  busy_d;
    logic        rdy_q,   rdy_d;
    logic        bit_end;

    assign bit_end = (timer_q == BIT_LAST);

    // Next-state, bit timing and registered-output decode.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 16'd1;
        idx_d   = idx_q;
        shreg_d = shreg_q;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (char_valid && rdy_q) begin
                    // The byte is captured here; char_in is not looked at again until IDLE.
                    shreg_d = char_in;
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase

        // Line level is decoded from the next state so tx is a clean flop output.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[idx_d];
`ifdef UART_PARITY_EN
            PARITY:  tx_d = ^shreg_d;
`endif
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
        rdy_d  = (state_d == IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    // Ready is gated by rst_n so it is never seen high while reset is asserted.
    assign char_ready = rdy_q & rst_n;
    assign tx         = tx_q;
    assign busy       = busy_q;

endmodule

// File: doc/ascii_uart_tx.md
ASCII_UART_TX -- requirements
Module: ascii_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port char_in  input  8  ASCII byte from the upstream character-stream stage.
REQ-005 SHALL have port char_valid  input  1  char_in holds a byte to send.
REQ-006 SHALL have port char_ready  output  1  block can accept a byte this cycle.
REQ-007 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-008 SHALL have port busy  output  1  frame in progress.

Function
REQ-009 SHALL implement the FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-010 SHALL drive char_ready high only in IDLE and never while rst_n is low.
REQ-011 SHALL accept a byte on any rising edge where char_valid and char_ready are both high: latch char_in into the shift register, clear the bit-timer, go to START.
REQ-012 SHALL ignore char_in and char_valid in every state except IDLE; changes to char_in after acceptance SHALL NOT affect the frame in progress.
REQ-013 SHALL drive tx low starting the cycle after acceptance, for exactly CLKS_PER_BIT cycles (START).
REQ-014 SHALL in DATA send 8 bits LSB first, each held for exactly CLKS_PER_BIT cycles, using a 3-bit index that ends after bit 7.
REQ-015 SHALL in STOP drive tx high for exactly CLKS_PER_BIT cycles, then enter IDLE.
REQ-016 SHALL hold busy high from the first START cycle through the last STOP cycle, and low in IDLE; busy SHALL equal the inverse of char_ready outside reset.
REQ-017 SHALL use a bit-timer of 16 bits that counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary; no other width truncation is allowed.
REQ-018 SHALL spend exactly one cycle in IDLE between frames (tx high, char_ready high) when char_valid is held high continuously; frame-to-frame spacing SHALL be 10*CLKS_PER_BIT+1 cycles (11*CLKS_PER_BIT+1 with parity).
REQ-019 SHALL hold tx high and stay in IDLE indefinitely while char_valid is low.

Reset
REQ-020 SHALL, on any rising edge with rst_n low, set the state to IDLE, tx=1, busy=0, char_ready=0, the bit-timer, bit index and shift register to 0.
REQ-021 SHALL abort a frame on reset mid-frame: tx SHALL be high from the first edge after rst_n is sampled low, and the partial byte SHALL be discarded and not resent.
REQ-022 SHALL assert char_ready on the first cycle after the first edge with rst_n high.

Configuration
REQ-023 SHALL honour macro UART_PARITY_EN: when defined, the PARITY state follows DATA and drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles before STOP.
REQ-024 SHALL go from DATA straight to STOP when UART_PARITY_EN is undefined, with no parity logic present.

Verification
REQ-025 SHALL cover, with CLKS_PER_BIT=4, no parity: send 0x54 -> tx = 0 for 4 cycles, then bits 0,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles; busy high for exactly 40 cycles.
REQ-026 SHALL cover, with UART_PARITY_EN defined and CLKS_PER_BIT=4: send 0x54 -> parity bit 1 for 4 cycles before stop; busy high for 44 cycles.
REQ-027 SHALL cover back-to-back sends: char_valid held high with 0x61 then 0x6A -> char_ready high for exactly 1 cycle between frames; the start bits are 41 cycles apart; the second frame carries 0x6A.
REQ-028 SHALL cover input held off during a frame: char_in toggled and char_valid pulsed during a frame -> tx waveform unchanged, no extra frame sent.
REQ-029 SHALL cover reset mid-frame: rst_n low for 1 cycle during DATA bit 3 -> tx=1, busy=0, char_ready=0 next cycle; char_ready=1 the cycle after; no leftover bits sent.
REQ-030 SHALL cover the minimum timing: CLKS_PER_BIT=2, send 0xFF -> start bit 2 cycles low, then tx high 18 cycles; total frame 20 cycles.
